// File: rtl/tpu_job_arbiter_if.sv
// Bundle of requester, core and result-stream signals around the
// job arbiter; slave side is the arbiter, master side the environment.
interface tpu_job_arbiter_if;
  logic       r0_valid;
  logic [7:0] r0_data;
  logic       r0_transpose;
  logic       r0_ready;
  logic       r1_valid;
  logic [7:0] r1_data;
  logic       r1_transpose;
  logic       r1_ready;
  logic       core_load_en;
  logic [7:0] core_indata;
  logic       core_transpose;
  logic       core_done;
  logic [7:0] core_outdata;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_id;
  logic       res_last;
  logic       res_ready;
  logic [1:0] grant;
  logic       busy;
  logic       err_timeout;

  modport slave (
    input  r0_valid, r0_data, r0_transpose,
    input  r1_valid, r1_data, r1_transpose,
    output r0_ready, r1_ready,
    output core_load_en, core_indata, core_transpose,
    input  core_done, core_outdata,
    output res_valid, res_data, res_id, res_last,
    input  res_ready,
    output grant, busy, err_timeout
  );

  modport master (
    output r0_valid, r0_data, r0_transpose,
    output r1_valid, r1_data, r1_transpose,
    input  r0_ready, r1_ready,
    input  core_load_en, core_indata, core_transpose,
    output core_done, core_outdata,
    input  res_valid, res_data, res_id, res_last,
    output res_ready,
    input  grant, busy, err_timeout
  );
endinterface

// File: rtl/tpu_job_arbiter.sv
// Round-robin sharing of one 2x2 systolic core between two requesters:
// streams 8 operand bytes in, captures 8 result bytes, returns them.
module tpu_job_arbiter #(
  parameter int TIMEOUT = 32
) (
  input logic              clk,
  input logic              rst,
  tpu_job_arbiter_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT, CAPTURE, DRAIN
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic       owner, owner_nx;
  logic       last_owner, last_owner_nx;
  logic [2:0] beat_cnt;
  logic [2:0] cap_cnt;
  logic [2:0] rd_ptr;
  logic [7:0] tmo_cnt;
  logic       trans_q;
  logic [7:0] res_buf [8];

  logic       g_valid;
  logic       g_trans;
  logic [7:0] g_data;
  logic       beat_acc;
  logic       done_hit;
  logic       tmo_hit;
  logic       rd_acc;
  logic       drain_done;

  always_comb begin
    g_valid = owner ? bus.r1_valid : bus.r0_valid;
    g_trans = owner ? bus.r1_transpose : bus.r0_transpose;
    g_data  = owner ? bus.r1_data : bus.r0_data;
  end

  assign beat_acc   = (state == LOAD) && g_valid;
  assign done_hit   = (state == WAIT) && bus.core_done;
  assign tmo_hit    = (state == WAIT) && !bus.core_done
                      && (tmo_cnt == TMO_LAST);
  assign rd_acc     = (state == DRAIN) && bus.res_ready;
  assign drain_done = rd_acc && (rd_ptr == 3'd7);

  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_owner_nx = last_owner;
    unique case (state)
      IDLE: begin
        if (bus.r0_valid || bus.r1_valid) begin
          state_nx = LOAD;
          unique case (1'b1)
            bus.r0_valid && bus.r1_valid:  owner_nx = ~last_owner;
            bus.r0_valid && !bus.r1_valid: owner_nx = 1'b0;
            !bus.r0_valid && bus.r1_valid: owner_nx = 1'b1;
            default:                       owner_nx = owner;
          endcase
        end
      end
      LOAD: begin
        if (beat_acc && (beat_cnt == 3'd7))
          state_nx = WAIT;
      end
      WAIT: begin
        if (done_hit) begin
          state_nx = CAPTURE;
        end else if (tmo_hit) begin
          state_nx      = IDLE;
          last_owner_nx = owner;
        end
      end
      CAPTURE: begin
        if (cap_cnt == 3'd7)
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (drain_done) begin
          state_nx      = IDLE;
          last_owner_nx = owner;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_owner <= last_owner_nx;
    end
  end

  // Counters wrap to zero after their 8th step, ready for the next job.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      cap_cnt  <= '0;
      rd_ptr   <= '0;
      tmo_cnt  <= '0;
      trans_q  <= 1'b0;
      for (int i = 0; i < 8; i++)
        res_buf[i] <= '0;
    end else begin
      if (beat_acc)
        beat_cnt <= beat_cnt + 3'd1;
      if (beat_acc && (beat_cnt == 3'd0))
        trans_q <= g_trans;
      if (state == WAIT)
        tmo_cnt <= tmo_cnt + 8'd1;
      else
        tmo_cnt <= '0;
      if (done_hit) begin
        res_buf[0] <= bus.core_outdata;
        cap_cnt    <= 3'd1;
      end else if (state == CAPTURE) begin
        res_buf[cap_cnt] <= bus.core_outdata;
        cap_cnt          <= cap_cnt + 3'd1;
      end
      if (rd_acc)
        rd_ptr <= rd_ptr + 3'd1;
    end
  end

  // The first beat shows its own flag before it is latched.
  always_comb begin
    bus.r0_ready     = (state == LOAD) && !owner;
    bus.r1_ready     = (state == LOAD) && owner;
    bus.core_load_en = beat_acc;
    bus.core_indata  = (state == LOAD) ? g_data : 8'h00;
    if ((state == LOAD) && (beat_cnt == 3'd0))
      bus.core_transpose = g_trans;
    else
      bus.core_transpose = (state != IDLE) && trans_q;
    bus.res_valid   = (state == DRAIN);
    bus.res_data    = (state == DRAIN) ? res_buf[rd_ptr] : 8'h00;
    bus.res_id      = (state == DRAIN) && owner;
    bus.res_last    = (state == DRAIN) && (rd_ptr == 3'd7);
    bus.grant       = (state == IDLE) ? 2'b00 : {owner, ~owner};
    bus.busy        = (state != IDLE);
    bus.err_timeout = tmo_hit;
  end
endmodule

// File: tb/tb_tpu_job_arbiter.sv
// Directed bench for tpu_job_arbiter: plays requesters, the core
// and the result consumer in one linear stimulus sequence.
module tb_tpu_job_arbiter;
  localparam int TMO = 32;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   strobes;
  int   bad_grant;
  int   resv;

  tpu_job_arbiter_if bus ();

  tpu_job_arbiter #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.core_load_en) strobes++;
    if (bus.grant == 2'b11) bad_grant++;
    if (bus.r0_ready && bus.r1_ready) bad_grant++;
    if (bus.res_valid) resv++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.r0_ready, bus.r1_ready, bus.core_load_en,
                bus.core_indata, bus.core_transpose, bus.res_valid,
                bus.res_data, bus.res_id, bus.res_last, bus.grant,
                bus.busy, bus.err_timeout});
  endfunction

  task automatic set_req(input int who, input logic v,
                         input logic [7:0] d, input logic tr);
    if (who == 0) begin
      bus.r0_valid = v; bus.r0_data = d; bus.r0_transpose = tr;
    end else begin
      bus.r1_valid = v; bus.r1_data = d; bus.r1_transpose = tr;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_job(input int who, input logic [7:0] base,
                          input logic tr, input int gap_at,
                          input int gap_len);
    int n, g, cyc;
    logic gap, rdy;
    logic [1:0] oh;
    n = 0; g = 0; cyc = 0;
    oh = (who == 0) ? 2'b01 : 2'b10;
    while (n < 8 && cyc < 40) begin
      gap = (n == gap_at) && (g < gap_len);
      set_req(who, !gap, 8'(base + n), tr);
      @(negedge clk);
      rdy = (who == 0) ? bus.r0_ready : bus.r1_ready;
      if (gap) begin
        chk("load_gap", 32'(bus.core_load_en), 0);
        g++;
      end else if (rdy) begin
        chk("load_beat",
            32'({bus.grant, bus.core_load_en, bus.core_transpose,
                 bus.core_indata}),
            32'({oh, 1'b1, tr, 8'(base + n)}));
        n++;
      end
      tick();
      cyc++;
    end
    set_req(who, 1'b0, 8'h00, 1'b0);
    chk("load_beats", n, 8);
  endtask

  task automatic serve(input int delay, input logic [7:0] base,
                       input int nbytes, input logic tr);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (i == 0)
        chk("wait_outs",
            32'({bus.busy, bus.res_valid, bus.core_load_en,
                 bus.core_transpose}),
            32'({1'b1, 1'b0, 1'b0, tr}));
      tick();
    end
    for (int k = 0; k < nbytes; k++) begin
      bus.core_done    = (k == 0);
      bus.core_outdata = 8'(base + k);
      tick();
    end
    bus.core_done    = 1'b0;
    bus.core_outdata = 8'h00;
  endtask

  task automatic drain_res(input logic id, input logic [7:0] base,
                           input int stall_at, input int stall_len);
    int k, s, cyc;
    logic stall;
    k = 0; s = 0; cyc = 0;
    while (k < 8 && cyc < 60) begin
      stall = (k == stall_at) && (s < stall_len);
      bus.res_ready = !stall;
      @(negedge clk);
      chk("res_beat",
          32'({bus.res_valid, bus.res_id, bus.res_last, bus.res_data}),
          32'({1'b1, id, (k == 7), 8'(base + k)}));
      if (stall) s++;
      else k++;
      tick();
      cyc++;
    end
    bus.res_ready = 1'b0;
    chk("drain_count", k, 8);
    @(negedge clk);
    chk("drain_idle", 32'({bus.busy, bus.grant, bus.res_valid}), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, pulses, pos, rv0;
    errors = 0; checks = 0; strobes = 0; bad_grant = 0; resv = 0;
    rst = 1'b1;
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    bus.core_done = 1'b0;
    bus.core_outdata = 8'h00;
    bus.res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", outs(), 0);

    bus.core_done = 1'b1;
    @(negedge clk);
    chk("done_in_idle", 32'(bus.busy), 0);
    bus.core_done = 1'b0;

    // single job from r0 with transpose
    load_job(0, 8'h01, 1'b1, 99, 0);
    serve(4, 8'hA0, 8, 1'b1);
    drain_res(1'b0, 8'hA0, 99, 0);

    // simultaneous requests; r0 keeps valid through its drain
    do_reset();
    set_req(1, 1'b1, 8'h11, 1'b0);
    load_job(0, 8'h21, 1'b0, 99, 0);
    set_req(0, 1'b1, 8'h55, 1'b0);
    serve(2, 8'hB0, 8, 1'b0);
    drain_res(1'b0, 8'hB0, 99, 0);
    load_job(1, 8'h11, 1'b0, 99, 0);
    set_req(0, 1'b0, 8'h00, 1'b0);
    serve(3, 8'hC0, 8, 1'b0);
    drain_res(1'b1, 8'hC0, 3, 5);
    chk("grant_onehot", bad_grant, 0);

    // valid gap in load
    do_reset();
    s0 = strobes;
    load_job(0, 8'h41, 1'b0, 4, 3);
    chk("gap_strobes", strobes - s0, 8);
    serve(1, 8'hD0, 8, 1'b0);
    drain_res(1'b0, 8'hD0, 99, 0);

    // timeout with both requesters pending
    do_reset();
    set_req(1, 1'b1, 8'h31, 1'b0);
    load_job(0, 8'h61, 1'b0, 99, 0);
    set_req(0, 1'b1, 8'h66, 1'b0);
    rv0 = resv;
    pulses = 0; pos = -1;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (bus.err_timeout) begin
        pulses++;
        pos = i;
      end
      tick();
    end
    @(negedge clk);
    chk("tmo_pulses", pulses, 1);
    chk("tmo_pos", pos, TMO - 1);
    chk("tmo_idle", 32'({bus.busy, bus.err_timeout}), 0);
    chk("tmo_no_res", resv - rv0, 0);
    load_job(1, 8'h31, 1'b0, 99, 0);
    set_req(0, 1'b0, 8'h00, 1'b0);
    serve(2, 8'hE0, 8, 1'b0);
    drain_res(1'b1, 8'hE0, 99, 0);

    // reset in the middle of capture
    do_reset();
    load_job(0, 8'h71, 1'b1, 99, 0);
    serve(2, 8'h90, 3, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_capture", outs(), 0);
    load_job(0, 8'h81, 1'b0, 99, 0);
    serve(0, 8'hF0, 8, 1'b0);
    drain_res(1'b0, 8'hF0, 99, 0);
    chk("grant_final", bad_grant, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
